// File: rtl/acc_seq_pkg.sv
// Shared encodings for the accumulator processor sequencer: opcodes, states, ALU codes.
package acc_seq_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned ALU_W = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_READ   = 3'd3,
    S_EXEC   = 3'd4,
    S_WRITE  = 3'd5,
    S_HALTED = 3'd6,
    S_TRAP   = 3'd7
  } state_e;

  localparam logic [OP_W-1:0] OP_HALT  = 3'b000;
  localparam logic [OP_W-1:0] OP_LOAD  = 3'b001;
  localparam logic [OP_W-1:0] OP_STORE = 3'b010;
  localparam logic [OP_W-1:0] OP_ADD   = 3'b011;
  localparam logic [OP_W-1:0] OP_SUB   = 3'b100;
  localparam logic [OP_W-1:0] OP_AND   = 3'b101;
  localparam logic [OP_W-1:0] OP_JMP   = 3'b110;
  localparam logic [OP_W-1:0] OP_JZ    = 3'b111;

  localparam logic [ALU_W-1:0] ALU_PASS = 2'b00;
  localparam logic [ALU_W-1:0] ALU_ADD  = 2'b01;
  localparam logic [ALU_W-1:0] ALU_SUB  = 2'b10;
  localparam logic [ALU_W-1:0] ALU_AND  = 2'b11;

  // ALU operation applied when an operand read completes; LOAD passes memory through.
  function automatic logic [ALU_W-1:0] alu_code(input logic [OP_W-1:0] opcode);
    case (opcode)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/acc_seq_wait_timer.sv
// Counts cycles a memory request has waited for its ack and flags a timeout.
module acc_seq_wait_timer
  import acc_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic clear,
  input  logic enable,
  input  logic ack,
  output logic expired
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0] count;

  // Saturates at the limit so the compare stays valid if the FSM lingers.
  always_ff @(posedge clock) begin
    if (clear || !enable || ack) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + CNT_W'(1);
    end
  end

  // A same-cycle ack beats the timeout.
  assign expired = (MEM_TIMEOUT != 0) && enable && !ack && (count == LIMIT);

endmodule

// File: rtl/accumulator_sequencer.sv
// Fetch/decode/execute controller for the accumulator processor; owns PC and IR
// and drives the memory port and the datapath load/ALU strobes.
module accumulator_sequencer
  import acc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TRAP_ON_OVF = 1
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     mem_ack,
  input  logic [OP_W+ADDR_W-1:0]   mem_rdata,
  input  logic                     flag_z,
  input  logic                     flag_v,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     acc_load,
  output logic [ALU_W-1:0]         alu_op,
  output logic [ADDR_W-1:0]        pc,
  output logic                     busy,
  output logic                     halted,
  output logic                     trap,
  output logic                     trap_cause
);

  localparam int unsigned IW = OP_W + ADDR_W;

  state_e            state;
  logic [IW-1:0]     ir;
  logic              cause_q;
  logic [OP_W-1:0]   opcode;
  logic [ADDR_W-1:0] operand;
  logic              req_state;
  logic              timeout;
  logic              ovf_trap;

  assign opcode    = ir[IW-1:ADDR_W];
  assign operand   = ir[ADDR_W-1:0];
  assign req_state = (state == S_FETCH) || (state == S_READ) || (state == S_WRITE);
  assign ovf_trap  = (TRAP_ON_OVF != 0) && ((opcode == OP_ADD) || (opcode == OP_SUB)) && flag_v;

  acc_seq_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clock   (clock),
    .clear   (clear),
    .enable  (req_state),
    .ack     (mem_ack),
    .expired (timeout)
  );

  // Sequencer state, PC, IR and trap cause.
  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      cause_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALTED, S_TRAP: begin
          if (start) begin
            pc      <= '0;
            cause_q <= 1'b0;
            state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            ir    <= mem_rdata;
            pc    <= pc + ADDR_W'(1);
            state <= S_DECODE;
          end else if (timeout) begin
            cause_q <= 1'b1;
            state   <= S_TRAP;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_ADD, OP_SUB, OP_AND: state <= S_READ;
            OP_STORE:                        state <= S_WRITE;
            OP_JMP: begin
              pc    <= operand;
              state <= S_FETCH;
            end
            OP_JZ: begin
              if (flag_z) begin
                pc <= operand;
              end
              state <= S_FETCH;
            end
            default:                         state <= S_HALTED;
          endcase
        end
        S_READ: begin
          if (mem_ack) begin
            state <= S_EXEC;
          end else if (timeout) begin
            cause_q <= 1'b1;
            state   <= S_TRAP;
          end
        end
        S_EXEC: begin
          if (ovf_trap) begin
            cause_q <= 1'b0;
            state   <= S_TRAP;
          end else begin
            state <= S_FETCH;
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            state <= S_FETCH;
          end else if (timeout) begin
            cause_q <= 1'b1;
            state   <= S_TRAP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory port and datapath strobes decode from registered state only; acc_load follows the ack.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    alu_op   = ALU_PASS;
    acc_load = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
      end
      S_READ: begin
        mem_req  = 1'b1;
        mem_addr = operand;
        alu_op   = alu_code(opcode);
        acc_load = mem_ack;
      end
      S_WRITE: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = operand;
      end
      default: ;
    endcase
  end

  assign busy       = !((state == S_IDLE) || (state == S_HALTED) || (state == S_TRAP));
  assign halted     = (state == S_HALTED);
  assign trap       = (state == S_TRAP);
  assign trap_cause = cause_q && (state == S_TRAP);

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Directed bench for accumulator_sequencer: bench-side memory served from the stimulus thread.
module tb_accumulator_sequencer;
  import acc_seq_pkg::*;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned IW     = OP_W + ADDR_W;

  logic              clock = 1'b0;
  logic              clear;
  logic              start;
  logic              mem_ack;
  logic [IW-1:0]     mem_rdata;
  logic              flag_z;
  logic              flag_v;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              acc_load;
  logic [1:0]        alu_op;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;
  logic              trap;
  logic              trap_cause;

  logic [IW-1:0] mem [32];
  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  accumulator_sequencer #(
    .ADDR_W      (ADDR_W),
    .MEM_TIMEOUT (15),
    .TRAP_ON_OVF (1)
  ) dut (
    .clock      (clock),
    .clear      (clear),
    .start      (start),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .flag_z     (flag_z),
    .flag_v     (flag_v),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .acc_load   (acc_load),
    .alu_op     (alu_op),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .trap       (trap),
    .trap_cause (trap_cause)
  );

  function automatic logic [IW-1:0] ins(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] a);
    return {op, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Wait for a request, hold ack low for 'waits' cycles, then ack one cycle.
  task automatic serve(input int waits, output logic [ADDR_W-1:0] a, output logic w,
                       output logic ld, output logic [1:0] op);
    int n;
    n  = 0;
    a  = '0;
    w  = 1'b0;
    ld = 1'b0;
    op = '0;
    while (mem_req !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (mem_req !== 1'b1) begin
      chk("serve_req_seen", 32'(mem_req), 32'd1);
      return;
    end
    repeat (waits) @(negedge clock);
    a         = mem_addr;
    w         = mem_we;
    mem_ack   = 1'b1;
    mem_rdata = mem[mem_addr];
    #1;
    ld = acc_load;
    op = alu_op;
    @(negedge clock);
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] a;
    logic              w;
    logic              ld;
    logic [1:0]        op;
    int                n;

    clear     = 1'b1;
    start     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    flag_z    = 1'b0;
    flag_v    = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    repeat (2) @(negedge clock);

    // Reset state
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_acc_load", 32'(acc_load), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    clear = 1'b0;

    // Program LOAD 10, ADD 11, STORE 12, HALT with one wait per access
    mem[0]  = ins(OP_LOAD, 5'd10);
    mem[1]  = ins(OP_ADD, 5'd11);
    mem[2]  = ins(OP_STORE, 5'd12);
    mem[3]  = ins(OP_HALT, 5'd0);
    mem[10] = 8'd3;
    mem[11] = 8'd4;
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_first_fetch_addr", 32'(mem_addr), 32'd0);
    serve(1, a, w, ld, op);
    chk("t1_f0_addr", 32'(a), 32'd0);
    chk("t1_f0_no_load", 32'(ld), 32'd0);
    serve(1, a, w, ld, op);
    chk("t1_load_addr", 32'(a), 32'd10);
    chk("t1_load_strobe", 32'(ld), 32'd1);
    chk("t1_load_op", 32'(op), 32'd0);
    serve(1, a, w, ld, op);
    chk("t1_f1_addr", 32'(a), 32'd1);
    serve(1, a, w, ld, op);
    chk("t1_add_addr", 32'(a), 32'd11);
    chk("t1_add_strobe", 32'(ld), 32'd1);
    chk("t1_add_op", 32'(op), 32'd1);
    serve(1, a, w, ld, op);
    chk("t1_f2_addr", 32'(a), 32'd2);
    serve(1, a, w, ld, op);
    chk("t1_store_addr", 32'(a), 32'd12);
    chk("t1_store_we", 32'(w), 32'd1);
    chk("t1_store_no_load", 32'(ld), 32'd0);
    serve(1, a, w, ld, op);
    chk("t1_f3_addr", 32'(a), 32'd3);
    @(negedge clock);
    chk("t1_halted", 32'(halted), 32'd1);
    chk("t1_pc", 32'(pc), 32'd4);
    chk("t1_not_busy", 32'(busy), 32'd0);
    chk("t1_no_req", 32'(mem_req), 32'd0);

    // JZ not taken, JMP loop, then JZ taken
    mem[0] = ins(OP_JZ, 5'd7);
    mem[1] = ins(OP_JMP, 5'd0);
    mem[7] = ins(OP_HALT, 5'd0);
    flag_z = 1'b0;
    pulse_start();
    serve(0, a, w, ld, op);
    chk("t2_f0_addr", 32'(a), 32'd0);
    serve(0, a, w, ld, op);
    chk("t2_jz_not_taken", 32'(a), 32'd1);
    serve(0, a, w, ld, op);
    chk("t2_jmp_loop", 32'(a), 32'd0);
    flag_z = 1'b1;
    serve(0, a, w, ld, op);
    chk("t2_jz_taken", 32'(a), 32'd7);
    @(negedge clock);
    chk("t2_halted", 32'(halted), 32'd1);
    chk("t2_pc", 32'(pc), 32'd8);
    flag_z = 1'b0;

    // ADD overflow traps
    mem[0] = ins(OP_ADD, 5'd11);
    flag_v = 1'b1;
    pulse_start();
    serve(0, a, w, ld, op);
    chk("t3_f0_addr", 32'(a), 32'd0);
    serve(0, a, w, ld, op);
    chk("t3_add_strobe", 32'(ld), 32'd1);
    chk("t3_add_op", 32'(op), 32'd1);
    @(negedge clock);
    chk("t3_trap", 32'(trap), 32'd1);
    chk("t3_trap_cause", 32'(trap_cause), 32'd0);
    chk("t3_not_busy", 32'(busy), 32'd0);
    chk("t3_no_req", 32'(mem_req), 32'd0);
    flag_v = 1'b0;
    mem[0] = ins(OP_LOAD, 5'd20);
    mem[1] = ins(OP_HALT, 5'd0);
    pulse_start();
    chk("t3_restart_trap", 32'(trap), 32'd0);
    chk("t3_restart_req", 32'(mem_req), 32'd1);
    chk("t3_restart_addr", 32'(mem_addr), 32'd0);

    // READ never acked -> timeout after 16 request cycles
    serve(0, a, w, ld, op);
    chk("t4_f0_addr", 32'(a), 32'd0);
    for (int k = 0; k < 4 && mem_req !== 1'b1; k++) @(negedge clock);
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      @(negedge clock);
    end
    chk("t4_req_cycles", 32'(n), 32'd16);
    chk("t4_trap", 32'(trap), 32'd1);
    chk("t4_trap_cause", 32'(trap_cause), 32'd1);
    chk("t4_not_busy", 32'(busy), 32'd0);

    // Ack on the 16th cycle wins over the timeout
    pulse_start();
    chk("t4_cause_cleared", 32'(trap_cause), 32'd0);
    serve(0, a, w, ld, op);
    chk("t4b_f0_addr", 32'(a), 32'd0);
    serve(15, a, w, ld, op);
    chk("t4b_read_addr", 32'(a), 32'd20);
    chk("t4b_late_ack_load", 32'(ld), 32'd1);
    chk("t4b_no_trap", 32'(trap), 32'd0);
    chk("t4b_busy", 32'(busy), 32'd1);
    @(negedge clock);
    chk("t4b_fetch_addr", 32'(mem_addr), 32'd1);
    pulse_start();
    chk("t5_start_ignored_addr", 32'(mem_addr), 32'd1);
    chk("t5_start_ignored_req", 32'(mem_req), 32'd1);
    chk("t5_start_ignored_pc", 32'(pc), 32'd1);
    serve(0, a, w, ld, op);
    chk("t4b_f1_addr", 32'(a), 32'd1);
    @(negedge clock);
    chk("t4b_halted", 32'(halted), 32'd1);

    // Clear during a pending write
    mem[0] = ins(OP_STORE, 5'd5);
    pulse_start();
    serve(0, a, w, ld, op);
    chk("t5_f0_addr", 32'(a), 32'd0);
    for (int k = 0; k < 4 && mem_req !== 1'b1; k++) @(negedge clock);
    chk("t5_write_we", 32'(mem_we), 32'd1);
    chk("t5_write_addr", 32'(mem_addr), 32'd5);
    clear = 1'b1;
    @(negedge clock);
    chk("t5_clr_req", 32'(mem_req), 32'd0);
    chk("t5_clr_we", 32'(mem_we), 32'd0);
    chk("t5_clr_addr", 32'(mem_addr), 32'd0);
    chk("t5_clr_load", 32'(acc_load), 32'd0);
    chk("t5_clr_alu_op", 32'(alu_op), 32'd0);
    chk("t5_clr_pc", 32'(pc), 32'd0);
    chk("t5_clr_busy", 32'(busy), 32'd0);
    chk("t5_clr_halted", 32'(halted), 32'd0);
    chk("t5_clr_trap", 32'(trap), 32'd0);
    chk("t5_clr_cause", 32'(trap_cause), 32'd0);
    clear = 1'b0;

    // PC wrap after fetching address 31
    mem[0]  = ins(OP_JMP, 5'd31);
    mem[31] = ins(OP_HALT, 5'd0);
    pulse_start();
    serve(0, a, w, ld, op);
    chk("t6_f0_addr", 32'(a), 32'd0);
    serve(0, a, w, ld, op);
    chk("t6_fetch31", 32'(a), 32'd31);
    chk("t6_pc_wrap", 32'(pc), 32'd0);
    @(negedge clock);
    chk("t6_halted", 32'(halted), 32'd1);
    chk("t6_halted_pc", 32'(pc), 32'd0);

    // Clear beats start
    clear = 1'b1;
    start = 1'b1;
    @(negedge clock);
    chk("t6_clr_start_busy", 32'(busy), 32'd0);
    chk("t6_clr_start_halted", 32'(halted), 32'd0);
    chk("t6_clr_start_req", 32'(mem_req), 32'd0);
    clear = 1'b0;
    start = 1'b0;
    @(negedge clock);
    chk("t6_idle_stays", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
